// File: rtl/simt_stack_ctrl_pkg.sv
// Shared SP branch-path types: branch ops, error codes, SIMT stack entry and controller state.
package simt_stack_ctrl_pkg;

  localparam int SIMT_STACK_DEPTH = 16;
  localparam int SIMT_WARP_SIZE   = 32;
  localparam int SIMT_PC_WIDTH    = 32;

  typedef enum logic [2:0] {
    BRA_NOP      = 3'd0,
    BRA_PC_ADD_4 = 3'd1,
    BRA_JUMP     = 3'd2,
    BRA_BRANCH   = 3'd3,
    BRA_PUSH     = 3'd4,
    BRA_POP      = 3'd5,
    BRA_FLUSH    = 3'd6
  } branch_op_t;

  localparam logic [31:0] KIANA_SP_ERR_STACK_OVERFLOW         = 32'h0000_0020;
  localparam logic [31:0] KIANA_SP_ERR_STACK_UNDERFLOW        = 32'h0000_0040;
  localparam logic [31:0] KIANA_SP_ERR_BRANCH_UNIT_INVALID_OP = 32'h0000_0080;

  typedef struct packed {
    logic [SIMT_PC_WIDTH-1:0]  pc;
    logic [SIMT_WARP_SIZE-1:0] mask;
  } simt_stack_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PUSH2 = 2'd1,
    ST_RESP  = 2'd2
  } simt_ctrl_state_t;

  function automatic logic [SIMT_PC_WIDTH-1:0] pc_plus4(input logic [SIMT_PC_WIDTH-1:0] pc);
    return pc + SIMT_PC_WIDTH'(4);
  endfunction

endpackage

// File: rtl/simt_stack_ctrl_mem.sv
// Reconvergence LIFO: DEPTH entries of {pc, mask}; push/pop are ignored when full/empty.
module simt_stack_ctrl_mem
  import simt_stack_ctrl_pkg::*;
#(
  parameter int DEPTH = SIMT_STACK_DEPTH,
  localparam int SPW  = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  simt_stack_entry_t wdata_i,
  output simt_stack_entry_t top_o,
  output logic [SPW-1:0]    sp_o,
  output logic              full_o,
  output logic              empty_o
);

  simt_stack_entry_t mem_q [DEPTH];
  logic [SPW-1:0]    sp_q, sp_d;

  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == {SPW{1'b0}});
  assign sp_o    = sp_q;
  assign top_o   = mem_q[AW'(sp_q - SPW'(1))];

  always_comb begin
    sp_d = sp_q;
    if (flush_i) begin
      sp_d = {SPW{1'b0}};
    end else if (push_i && !full_o) begin
      sp_d = sp_q + SPW'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SPW'(1);
    end else begin
      sp_d = sp_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= {SPW{1'b0}};
    else        sp_q <= sp_d;
  end

  // Storage needs no reset: entries above sp are never read as valid.
  always_ff @(posedge clk) begin
    if (push_i && !full_o && !flush_i) mem_q[AW'(sp_q)] <= wdata_i;
  end

endmodule

// File: rtl/simt_stack_ctrl.sv
// Per-warp SIMT divergence/reconvergence controller.
// Optional KIANA_SIMT_STACK_OCCUPANCY_EN adds depth_o and high_water_o.
module simt_stack_ctrl
  import simt_stack_ctrl_pkg::*;
#(
  parameter int WARP_SIZE = SIMT_WARP_SIZE,
  parameter int PC_WIDTH  = SIMT_PC_WIDTH,
  parameter int DEPTH     = SIMT_STACK_DEPTH,
  localparam int SPW      = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [2:0]           req_op_i,
  input  logic [PC_WIDTH-1:0]  req_pc_i,
  input  logic [PC_WIDTH-1:0]  req_target_i,
  input  logic [PC_WIDTH-1:0]  req_reconv_pc_i,
  input  logic [WARP_SIZE-1:0] req_taken_mask_i,
  output logic                 resp_valid_o,
  output logic [PC_WIDTH-1:0]  next_pc_o,
  output logic [WARP_SIZE-1:0] active_mask_o,
  input  logic                 err_clr_i,
  output logic [31:0]          err_o
`ifdef KIANA_SIMT_STACK_OCCUPANCY_EN
  ,
  output logic [SPW-1:0]       depth_o,
  output logic [SPW-1:0]       high_water_o
`endif
);

  simt_ctrl_state_t     state_q, state_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [PC_WIDTH-1:0]  next_pc_q, next_pc_d, pc4_q, pc4_d, tgt_q, tgt_d;
  logic [WARP_SIZE-1:0] mask_q, mask_d, taken_q, taken_d, taken_s;
  logic [31:0]          err_q, err_d, fault_s;
  logic                 accept_s, divergent_s, go_push2_s;
  logic                 push_s, pop_s, flush_s, full_s, empty_s;
  logic [SPW-1:0]       sp_s;
  simt_stack_entry_t    entry_s, top_s;
  branch_op_t           op_s;

  simt_stack_ctrl_mem #(.DEPTH(DEPTH)) u_mem (
    .clk(clk), .rst_n(rst_n), .push_i(push_s), .pop_i(pop_s), .flush_i(flush_s),
    .wdata_i(entry_s), .top_o(top_s), .sp_o(sp_s), .full_o(full_s), .empty_o(empty_s)
  );

  assign op_s        = branch_op_t'(req_op_i);
  assign accept_s    = req_valid_i && (state_q == ST_IDLE);
  assign taken_s     = req_taken_mask_i & mask_q;
  assign divergent_s = (taken_s != mask_q) && (taken_s != {WARP_SIZE{1'b0}});
  // Both pushes of a divergent branch must fit, so room for two is checked up front.
  assign go_push2_s  = accept_s && (op_s == BRA_BRANCH) && divergent_s &&
                       (sp_s <= SPW'(DEPTH - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_s) state_d = go_push2_s ? ST_PUSH2 : ST_RESP;
                else          state_d = ST_IDLE;
      ST_PUSH2: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    push_s = 1'b0; pop_s = 1'b0; flush_s = 1'b0; entry_s = '0; fault_s = 32'h0;
    next_pc_d = next_pc_q; mask_d = mask_q; resp_valid_d = 1'b0;
    pc4_d = pc4_q; tgt_d = tgt_q; taken_d = taken_q;
    if (accept_s) begin
      resp_valid_d = 1'b1;
      next_pc_d    = pc_plus4(req_pc_i);
      case (op_s)
        BRA_BRANCH: begin
          if (taken_s == mask_q) begin
            next_pc_d = req_target_i;
          end else if (!divergent_s) begin
            next_pc_d = pc_plus4(req_pc_i);
          end else if (go_push2_s) begin
            push_s       = 1'b1;
            entry_s.pc   = req_reconv_pc_i;
            entry_s.mask = mask_q;
            pc4_d        = pc_plus4(req_pc_i);
            tgt_d        = req_target_i;
            taken_d      = taken_s;
            resp_valid_d = 1'b0;
          end else begin
            fault_s = KIANA_SP_ERR_STACK_OVERFLOW;
          end
        end
        BRA_POP: begin
          if (!empty_s) begin
            pop_s     = 1'b1;
            next_pc_d = top_s.pc;
            mask_d    = top_s.mask;
          end else begin
            fault_s = KIANA_SP_ERR_STACK_UNDERFLOW;
          end
        end
        BRA_PUSH: begin
          if (!full_s) begin
            push_s       = 1'b1;
            entry_s.pc   = req_reconv_pc_i;
            entry_s.mask = mask_q;
          end else begin
            fault_s = KIANA_SP_ERR_STACK_OVERFLOW;
          end
        end
        BRA_JUMP:     next_pc_d = req_target_i;
        BRA_FLUSH: begin
          flush_s   = 1'b1;
          mask_d    = {WARP_SIZE{1'b1}};
          next_pc_d = req_target_i;
        end
        BRA_PC_ADD_4, BRA_NOP: next_pc_d = pc_plus4(req_pc_i);
        default:      fault_s = KIANA_SP_ERR_BRANCH_UNIT_INVALID_OP;
      endcase
    end else if (state_q == ST_PUSH2) begin
      push_s       = 1'b1;
      entry_s.pc   = pc4_q;
      entry_s.mask = mask_q & ~taken_q;
      next_pc_d    = tgt_q;
      mask_d       = taken_q;
      resp_valid_d = 1'b1;
    end else begin
      resp_valid_d = 1'b0;
    end
    // A fault raised in the clearing cycle must survive the clear.
    err_d = (err_clr_i ? 32'h0 : err_q) | fault_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      next_pc_q    <= {PC_WIDTH{1'b0}};
      mask_q       <= {WARP_SIZE{1'b1}};
      err_q        <= 32'h0;
      pc4_q        <= {PC_WIDTH{1'b0}};
      tgt_q        <= {PC_WIDTH{1'b0}};
      taken_q      <= {WARP_SIZE{1'b0}};
    end else begin
      resp_valid_q <= resp_valid_d;
      next_pc_q    <= next_pc_d;
      mask_q       <= mask_d;
      err_q        <= err_d;
      pc4_q        <= pc4_d;
      tgt_q        <= tgt_d;
      taken_q      <= taken_d;
    end
  end

  always_comb begin
    req_ready_o   = (state_q == ST_IDLE);
    resp_valid_o  = resp_valid_q;
    next_pc_o     = next_pc_q;
    active_mask_o = mask_q;
    err_o         = err_q;
  end

`ifdef KIANA_SIMT_STACK_OCCUPANCY_EN
  logic [SPW-1:0] high_water_q, high_water_d, hw_base_s;

  always_comb begin
    hw_base_s    = err_clr_i ? {SPW{1'b0}} : high_water_q;
    high_water_d = (sp_s > hw_base_s) ? sp_s : hw_base_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) high_water_q <= {SPW{1'b0}};
    else        high_water_q <= high_water_d;
  end

  assign depth_o      = sp_s;
  assign high_water_o = high_water_q;
`endif

endmodule

// File: tb/tb_simt_stack_ctrl.sv
// Scoreboard bench for simt_stack_ctrl: expected {pc, mask, latency} queued at issue, checked at resp.
module tb_simt_stack_ctrl;
  import simt_stack_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_op_i = 3'd0;
  logic [31:0] req_pc_i = 32'h0, req_target_i = 32'h0, req_reconv_pc_i = 32'h0;
  logic [31:0] req_taken_mask_i = 32'h0;
  logic        resp_valid_o;
  logic [31:0] next_pc_o, active_mask_o, err_o;
  logic        err_clr_i = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] mask;
    int          lat;
  } exp_t;
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  simt_stack_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_pc_i(req_pc_i), .req_target_i(req_target_i),
    .req_reconv_pc_i(req_reconv_pc_i), .req_taken_mask_i(req_taken_mask_i),
    .resp_valid_o(resp_valid_o), .next_pc_o(next_pc_o), .active_mask_o(active_mask_o),
    .err_clr_i(err_clr_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Drives one command, queues its expectation, and checks the response against the scoreboard.
  task automatic issue(input logic [2:0] op, input logic [31:0] pc, tgt, reconv, taken,
                       input logic clr, input logic [31:0] e_pc, e_mask, input int e_lat,
                       input string name);
    exp_t e;
    int   cyc;
    req_valid_i = 1'b1; req_op_i = op; req_pc_i = pc; req_target_i = tgt;
    req_reconv_pc_i = reconv; req_taken_mask_i = taken; err_clr_i = clr;
    sb_q.push_back('{e_pc, e_mask, e_lat});
    checks++;
    if (req_ready_o !== 1'b1) begin
      $display("FAIL %s ready_at_issue got %b want 1", name, req_ready_o); errors++;
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0; err_clr_i = 1'b0;
    cyc = 1;
    while (resp_valid_o !== 1'b1 && cyc < 10) begin
      checks++;
      if (req_ready_o !== 1'b0) begin
        $display("FAIL %s busy_ready got %b want 0", name, req_ready_o); errors++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    e = sb_q.pop_front();
    checks++;
    if (resp_valid_o !== 1'b1) begin
      $display("FAIL %s resp_timeout got no resp after %0d cycles", name, cyc); errors++;
    end else begin
      checks += 4;
      if (next_pc_o !== e.pc) begin
        $display("FAIL %s next_pc got %h want %h", name, next_pc_o, e.pc); errors++;
      end
      if (active_mask_o !== e.mask) begin
        $display("FAIL %s mask got %h want %h", name, active_mask_o, e.mask); errors++;
      end
      if (cyc !== e.lat) begin
        $display("FAIL %s latency got %0d want %0d", name, cyc, e.lat); errors++;
      end
      if (req_ready_o !== 1'b0) begin
        $display("FAIL %s resp_ready got %b want 0", name, req_ready_o); errors++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks += 6;
    if (req_ready_o !== 1'b1) begin $display("FAIL rst_ready got %b want 1", req_ready_o); errors++; end
    if (resp_valid_o !== 1'b0) begin $display("FAIL rst_resp got %b want 0", resp_valid_o); errors++; end
    if (next_pc_o !== 32'h0) begin $display("FAIL rst_pc got %h want 0", next_pc_o); errors++; end
    if (active_mask_o !== 32'hFFFF_FFFF) begin $display("FAIL rst_mask got %h want ffffffff", active_mask_o); errors++; end
    if (err_o !== 32'h0) begin $display("FAIL rst_err got %h want 0", err_o); errors++; end
    if (dut.u_mem.sp_o !== 5'd0) begin $display("FAIL rst_sp got %0d want 0", dut.u_mem.sp_o); errors++; end
  endtask

  task automatic test_divergence();
    issue(BRA_BRANCH, 32'h100, 32'h200, 32'h300, 32'h0000_FFFF, 1'b0, 32'h200, 32'h0000_FFFF, 2, "div_branch");
    checks++;
    if (dut.u_mem.sp_o !== 5'd2) begin $display("FAIL div_sp got %0d want 2", dut.u_mem.sp_o); errors++; end
    issue(BRA_POP, 32'h200, 32'h0, 32'h0, 32'h0, 1'b0, 32'h104, 32'hFFFF_0000, 1, "div_pop1");
    issue(BRA_POP, 32'h104, 32'h0, 32'h0, 32'h0, 1'b0, 32'h300, 32'hFFFF_FFFF, 1, "div_pop2");
    checks += 2;
    if (dut.u_mem.sp_o !== 5'd0) begin $display("FAIL div_sp_end got %0d want 0", dut.u_mem.sp_o); errors++; end
    if (err_o !== 32'h0) begin $display("FAIL div_err got %h want 0", err_o); errors++; end
  endtask

  task automatic test_uniform();
    issue(BRA_BRANCH, 32'h400, 32'h800, 32'h900, 32'hFFFF_FFFF, 1'b0, 32'h800, 32'hFFFF_FFFF, 1, "uni_taken");
    issue(BRA_BRANCH, 32'h400, 32'h800, 32'h900, 32'h0, 1'b0, 32'h404, 32'hFFFF_FFFF, 1, "uni_not_taken");
    checks++;
    if (dut.u_mem.sp_o !== 5'd0) begin $display("FAIL uni_sp got %0d want 0", dut.u_mem.sp_o); errors++; end
  endtask

  task automatic test_underflow();
    issue(BRA_POP, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0, 32'h14, 32'hFFFF_FFFF, 1, "uflow_pop");
    checks++;
    if (err_o !== 32'h40) begin $display("FAIL uflow_err got %h want 40", err_o); errors++; end
    err_clr_i = 1'b1;
    @(posedge clk); #1;
    err_clr_i = 1'b0;
    checks++;
    if (err_o !== 32'h0) begin $display("FAIL uflow_clr got %h want 0", err_o); errors++; end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++)
      issue(BRA_PUSH, 32'h40 + 32'(i), 32'h0, 32'h1000 + 32'(i * 4), 32'h0, 1'b0,
            32'h44 + 32'(i), 32'hFFFF_FFFF, 1, "oflow_push");
    checks += 2;
    if (dut.u_mem.sp_o !== 5'd16) begin $display("FAIL oflow_sp16 got %0d want 16", dut.u_mem.sp_o); errors++; end
    if (err_o !== 32'h0) begin $display("FAIL oflow_err_pre got %h want 0", err_o); errors++; end
    issue(BRA_PUSH, 32'h80, 32'h0, 32'h2000, 32'h0, 1'b0, 32'h84, 32'hFFFF_FFFF, 1, "oflow_push17");
    checks += 2;
    if (err_o !== 32'h20) begin $display("FAIL oflow_err got %h want 20", err_o); errors++; end
    if (dut.u_mem.sp_o !== 5'd16) begin $display("FAIL oflow_sp_hold got %0d want 16", dut.u_mem.sp_o); errors++; end
    issue(BRA_POP, 32'h90, 32'h0, 32'h0, 32'h0, 1'b1, 32'h103C, 32'hFFFF_FFFF, 1, "oflow_pop_top");
    checks++;
    if (err_o !== 32'h0) begin $display("FAIL oflow_clr got %h want 0", err_o); errors++; end
    issue(BRA_BRANCH, 32'hA0, 32'hB0, 32'hC0, 32'h0000_FFFF, 1'b0, 32'hA4, 32'hFFFF_FFFF, 1, "oflow_div15");
    checks += 2;
    if (err_o !== 32'h20) begin $display("FAIL oflow_div_err got %h want 20", err_o); errors++; end
    if (dut.u_mem.sp_o !== 5'd15) begin $display("FAIL oflow_div_sp got %0d want 15", dut.u_mem.sp_o); errors++; end
  endtask

  task automatic test_invalid_flush();
    issue(3'd7, 32'h50, 32'h60, 32'h70, 32'h0, 1'b1, 32'h54, 32'hFFFF_FFFF, 1, "inv_op");
    checks += 2;
    if (err_o !== 32'h80) begin $display("FAIL inv_err got %h want 80", err_o); errors++; end
    if (dut.u_mem.sp_o !== 5'd15) begin $display("FAIL inv_sp got %0d want 15", dut.u_mem.sp_o); errors++; end
    issue(BRA_FLUSH, 32'h58, 32'h900, 32'h0, 32'h0, 1'b1, 32'h900, 32'hFFFF_FFFF, 1, "flush15");
    for (int i = 0; i < 3; i++)
      issue(BRA_PUSH, 32'h20, 32'h0, 32'h3000, 32'h0, 1'b0, 32'h24, 32'hFFFF_FFFF, 1, "flush_fill");
    issue(BRA_BRANCH, 32'h30, 32'h70, 32'h90, 32'h0000_00FF, 1'b0, 32'h70, 32'h0000_00FF, 2, "flush_div");
    checks++;
    if (dut.u_mem.sp_o !== 5'd5) begin $display("FAIL flush_sp5 got %0d want 5", dut.u_mem.sp_o); errors++; end
    issue(BRA_FLUSH, 32'h74, 32'hA00, 32'h0, 32'h0, 1'b0, 32'hA00, 32'hFFFF_FFFF, 1, "flush5");
    checks += 2;
    if (dut.u_mem.sp_o !== 5'd0) begin $display("FAIL flush_sp0 got %0d want 0", dut.u_mem.sp_o); errors++; end
    if (err_o !== 32'h0) begin $display("FAIL flush_err got %h want 0", err_o); errors++; end
  endtask

  task automatic test_pc_ops();
    issue(BRA_PC_ADD_4, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFF, 1, "pc_wrap");
    issue(BRA_NOP, 32'h8, 32'h0, 32'h0, 32'h0, 1'b0, 32'hC, 32'hFFFF_FFFF, 1, "nop");
    issue(BRA_JUMP, 32'h10, 32'h44, 32'h0, 32'h0, 1'b0, 32'h44, 32'hFFFF_FFFF, 1, "jump");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    req_valid_i = 1'b1; req_op_i = BRA_JUMP; req_pc_i = 32'h0; req_target_i = 32'h500;
    sb_q.push_back('{32'h500, 32'hFFFF_FFFF, 1});
    @(posedge clk); #1;
    req_target_i = 32'h600;
    e = sb_q.pop_front();
    checks += 3;
    if (resp_valid_o !== 1'b1) begin $display("FAIL b2b_resp1 got %b want 1", resp_valid_o); errors++; end
    if (next_pc_o !== e.pc) begin $display("FAIL b2b_pc1 got %h want %h", next_pc_o, e.pc); errors++; end
    if (req_ready_o !== 1'b0) begin $display("FAIL b2b_stall got %b want 0", req_ready_o); errors++; end
    sb_q.push_back('{32'h600, 32'hFFFF_FFFF, 1});
    @(posedge clk); #1;
    checks += 2;
    if (resp_valid_o !== 1'b0) begin $display("FAIL b2b_gap got %b want 0", resp_valid_o); errors++; end
    if (req_ready_o !== 1'b1) begin $display("FAIL b2b_idle got %b want 1", req_ready_o); errors++; end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    e = sb_q.pop_front();
    checks += 2;
    if (resp_valid_o !== 1'b1) begin $display("FAIL b2b_resp2 got %b want 1", resp_valid_o); errors++; end
    if (next_pc_o !== e.pc) begin $display("FAIL b2b_pc2 got %h want %h", next_pc_o, e.pc); errors++; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_push2();
    req_valid_i = 1'b1; req_op_i = BRA_BRANCH; req_pc_i = 32'h700; req_target_i = 32'h800;
    req_reconv_pc_i = 32'h900; req_taken_mask_i = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    checks += 2;
    if (req_ready_o !== 1'b0) begin $display("FAIL rp2_in_push2 got %b want 0", req_ready_o); errors++; end
    if (dut.u_mem.sp_o !== 5'd1) begin $display("FAIL rp2_sp1 got %0d want 1", dut.u_mem.sp_o); errors++; end
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (dut.u_mem.sp_o !== 5'd0) begin $display("FAIL rp2_sp0 got %0d want 0", dut.u_mem.sp_o); errors++; end
    if (req_ready_o !== 1'b1) begin $display("FAIL rp2_ready got %b want 1", req_ready_o); errors++; end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (resp_valid_o !== 1'b0) begin $display("FAIL rp2_no_resp got %b want 0", resp_valid_o); errors++; end
      @(posedge clk); #1;
    end
    checks += 3;
    if (req_ready_o !== 1'b1) begin $display("FAIL rp2_ready_after got %b want 1", req_ready_o); errors++; end
    if (active_mask_o !== 32'hFFFF_FFFF) begin $display("FAIL rp2_mask got %h want ffffffff", active_mask_o); errors++; end
    if (dut.u_mem.sp_o !== 5'd0) begin $display("FAIL rp2_sp_after got %0d want 0", dut.u_mem.sp_o); errors++; end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_divergence();
    test_uniform();
    test_underflow();
    test_overflow();
    test_invalid_flush();
    test_pc_ops();
    test_back_to_back();
    test_reset_push2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
